// File: rtl/mcs4_addr_stack.sv
// rtl/mcs4_addr_stack.sv - MCS-4 program counter with return-address stack
module mcs4_addr_stack #(
  parameter int Addr_width    = 12,
  parameter int Depth         = 3,
  parameter int Overflow_mode = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_inc,
  input  logic                         pc_load,
  input  logic                         call,
  input  logic                         ret,
  input  logic [Addr_width-1:0]        load_addr,
  input  logic                         clr_err,
  output logic [Addr_width-1:0]        pc,
  output logic [$clog2(Depth+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf_sticky,
  output logic                         unf_sticky
);

  localparam int DW  = $clog2(Depth + 1);
  localparam int PW  = $clog2(Depth);
  localparam bit Sat = (Overflow_mode == 1);

  logic [Addr_width-1:0] mem [0:Depth-1];
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_inc;
  logic [PW-1:0]         ptr_dec;

  // Circular pointer neighbours; Depth need not be a power of two
  always_comb begin
    ptr_inc = (ptr == PW'(Depth - 1)) ? '0 : ptr + PW'(1);
    ptr_dec = (ptr == '0) ? PW'(Depth - 1) : ptr - PW'(1);
  end

  // PC, stack storage and occupancy; ret > call > pc_load > pc_inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      ptr   <= '0;
      depth <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (ret) begin
      if (!empty) begin
        ptr   <= ptr_dec;
        pc    <= mem[ptr_dec];
        depth <= depth - DW'(1);
        empty <= (depth == DW'(1));
        full  <= 1'b0;
      end else if (!Sat) begin
        // 4004-style underflow: pointer still moves and a stale entry is read
        ptr <= ptr_dec;
        pc  <= mem[ptr_dec];
      end
    end else if (call) begin
      if (!full || !Sat) begin
        mem[ptr] <= pc;
        ptr      <= ptr_inc;
      end
      if (!full) begin
        depth <= depth + DW'(1);
        empty <= 1'b0;
        full  <= (depth == DW'(Depth - 1));
      end
      pc <= load_addr;
    end else if (pc_load) begin
      pc <= load_addr;
    end else if (pc_inc) begin
      pc <= pc + Addr_width'(1);
    end
  end

  // Sticky error flags; a same-cycle error event wins over clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (call && !ret && full) || (ovf_sticky && !clr_err);
      unf_sticky <= (ret && empty) || (unf_sticky && !clr_err);
    end
  end

endmodule

// File: tb/tb_mcs4_addr_stack.sv
// tb/tb_mcs4_addr_stack.sv - directed self-checking bench for mcs4_addr_stack
module tb_mcs4_addr_stack;

  logic        clk;
  logic        rst_n;
  logic        pc_inc;
  logic        pc_load;
  logic        call;
  logic        ret;
  logic [11:0] load_addr;
  logic        clr_err;

  logic [11:0] w_pc;
  logic [1:0]  w_depth;
  logic        w_empty, w_full, w_ovf, w_unf;
  logic [11:0] s_pc;
  logic [2:0]  s_depth;
  logic        s_empty, s_full, s_ovf, s_unf;

  int passed = 0;
  int total  = 0;

  mcs4_addr_stack u_wrap (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .pc_load(pc_load),
    .call(call), .ret(ret), .load_addr(load_addr), .clr_err(clr_err),
    .pc(w_pc), .depth(w_depth), .empty(w_empty), .full(w_full),
    .ovf_sticky(w_ovf), .unf_sticky(w_unf)
  );

  mcs4_addr_stack #(.Addr_width(12), .Depth(7), .Overflow_mode(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .pc_load(pc_load),
    .call(call), .ret(ret), .load_addr(load_addr), .clr_err(clr_err),
    .pc(s_pc), .depth(s_depth), .empty(s_empty), .full(s_full),
    .ovf_sticky(s_ovf), .unf_sticky(s_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic op(input logic c, input logic r, input logic l, input logic i,
                    input logic [11:0] a, input logic clr);
    call = c; ret = r; pc_load = l; pc_inc = i; load_addr = a; clr_err = clr;
    @(posedge clk);
    #1;
    call = 0; ret = 0; pc_load = 0; pc_inc = 0; load_addr = '0; clr_err = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; call = 0; ret = 0; pc_load = 0; pc_inc = 0; load_addr = '0; clr_err = 0;
    #12;
    chk("rst_pc", w_pc, 12'h000);
    chk("rst_depth", w_depth, 0);
    chk("rst_empty", w_empty, 1);
    chk("rst_full", w_full, 0);
    chk("rst_ovf", w_ovf, 0);
    chk("rst_unf", w_unf, 0);
    rst_n = 1;

    // PC wraps at the top of the address space
    op(0, 0, 1, 0, 12'hFFF, 0);
    chk("load_fff", w_pc, 12'hFFF);
    op(0, 0, 0, 1, 12'h000, 0);
    chk("inc_wrap_pc", w_pc, 12'h000);
    chk("inc_wrap_depth", w_depth, 0);
    chk("inc_wrap_ovf", w_ovf, 0);

    // WRAP D=3: overflow overwrites oldest, underflow reads stale entry
    op(0, 0, 1, 0, 12'h010, 0);
    op(1, 0, 0, 0, 12'h100, 0);
    chk("w_call1_pc", w_pc, 12'h100);
    chk("w_call1_depth", w_depth, 1);
    op(1, 0, 0, 0, 12'h200, 0);
    op(1, 0, 0, 0, 12'h300, 0);
    chk("w_call3_full", w_full, 1);
    chk("w_call3_depth", w_depth, 3);
    chk("w_call3_ovf", w_ovf, 0);
    op(1, 0, 0, 0, 12'h400, 0);
    chk("w_call4_pc", w_pc, 12'h400);
    chk("w_call4_ovf", w_ovf, 1);
    chk("w_call4_depth", w_depth, 3);
    op(0, 1, 0, 0, 12'h000, 0);
    chk("w_ret1_pc", w_pc, 12'h300);
    chk("w_ret1_depth", w_depth, 2);
    op(0, 1, 0, 0, 12'h000, 0);
    chk("w_ret2_pc", w_pc, 12'h200);
    op(0, 1, 0, 0, 12'h000, 0);
    chk("w_ret3_pc", w_pc, 12'h100);
    chk("w_ret3_empty", w_empty, 1);
    chk("w_ret3_unf", w_unf, 0);
    op(0, 1, 0, 0, 12'h000, 0);
    chk("w_ret4_pc", w_pc, 12'h300);
    chk("w_ret4_unf", w_unf, 1);
    chk("w_ret4_depth", w_depth, 0);

    // Async reset mid-run with depth=2, observed before any clock edge
    op(1, 0, 0, 0, 12'h050, 0);
    op(1, 0, 0, 0, 12'h060, 0);
    chk("pre_arst_depth", w_depth, 2);
    #1 rst_n = 0;
    #1;
    chk("arst_pc", w_pc, 12'h000);
    chk("arst_depth", w_depth, 0);
    chk("arst_empty", w_empty, 1);
    chk("arst_full", w_full, 0);
    chk("arst_ovf", w_ovf, 1'b0);
    chk("arst_unf", w_unf, 1'b0);
    #1 rst_n = 1;

    // ret+call+pc_inc together: only the pop happens
    op(0, 0, 1, 0, 12'h020, 0);
    op(1, 0, 0, 0, 12'h0A0, 0);
    chk("prio_setup_depth", w_depth, 1);
    op(1, 1, 0, 1, 12'h777, 0);
    chk("prio_pc", w_pc, 12'h020);
    chk("prio_depth", w_depth, 0);
    chk("prio_empty", w_empty, 1);
    chk("prio_ovf", w_ovf, 0);

    // clr_err loses to a same-cycle overflow, then clears alone
    op(1, 0, 0, 0, 12'h001, 0);
    op(1, 0, 0, 0, 12'h002, 0);
    op(1, 0, 0, 0, 12'h003, 0);
    op(1, 0, 0, 0, 12'h004, 0);
    chk("clr_setup_ovf", w_ovf, 1);
    op(1, 0, 0, 0, 12'h005, 1);
    chk("clr_vs_ovf", w_ovf, 1);
    op(0, 0, 0, 0, 12'h000, 1);
    chk("clr_alone_ovf", w_ovf, 0);
    chk("clr_alone_unf", w_unf, 0);

    // SATURATE D=7: 8th return address dropped, 8th ret leaves pc alone
    do_reset();
    op(0, 0, 1, 0, 12'h010, 0);
    for (int k = 0; k < 8; k++) begin
      op(1, 0, 0, 0, 12'h101 + 12'(k), 0);
      if (k == 6) begin
        chk("s_call7_full", s_full, 1);
        chk("s_call7_ovf", s_ovf, 0);
      end
    end
    chk("s_call8_pc", s_pc, 12'h108);
    chk("s_call8_ovf", s_ovf, 1);
    chk("s_call8_depth", s_depth, 7);
    for (int k = 0; k < 7; k++) begin
      op(0, 1, 0, 0, 12'h000, 0);
      chk($sformatf("s_ret%0d_pc", k + 1), s_pc, (k == 6) ? 32'h010 : 32'h106 - k);
      chk($sformatf("s_ret%0d_depth", k + 1), s_depth, 6 - k);
    end
    chk("s_ret7_unf", s_unf, 0);
    op(0, 1, 0, 0, 12'h000, 0);
    chk("s_ret8_pc", s_pc, 12'h010);
    chk("s_ret8_unf", s_unf, 1);
    chk("s_ret8_depth", s_depth, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
